// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that runs one full-adder cell over a WIDTH-bit add.
// The operands are fed LSB-first, one bit per clock. The carry is held in a flop
// between bits. The sum is assembled in a shift register, and a one-cycle done
// pulse marks when result/cout are valid.
// Optional build macro: SERIAL_ADD_CTRL_SUB_EN adds a 'sub' input for A - B
// (cout=1 means no borrow).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADD_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Single shared full-adder cell, returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Cell evaluation and next result word (sum enters at the MSB, word shifts right)
    always_comb begin
        {fa_c, fa_s} = full_add(a_sh[0], b_sh[0], carry);
        res_next     = (result >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // Operand B / carry-in selection at load time; subtract is A + ~B + 1
    always_comb begin
        b_load = op_b;
        c_load = cin;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        if (sub) begin
            b_load = ~op_b;
            c_load = 1'b1;
        end
`endif
    end

    // Control FSM plus the operand/result shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    result <= res_next;
                    if (cnt == LAST) begin
                        // Counter parks at WIDTH-1 rather than wrapping
                        cout  <= fa_c;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances.
// Define SERIAL_ADD_CTRL_SUB_EN to also exercise the subtract option.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;

    logic       start1;
    logic [0:0] op_a1;
    logic [0:0] op_b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] result1;
    logic       cout1;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    logic       sub;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
`ifdef SERIAL_ADD_CTRL_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start1),
        .op_a   (op_a1),
        .op_b   (op_b1),
        .cin    (cin1),
`ifdef SERIAL_ADD_CTRL_SUB_EN
        .sub    (1'b0),
`endif
        .busy   (busy1),
        .done   (done1),
        .result (result1),
        .cout   (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the 8-bit instance and check timing and result
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic s,
                        input logic [7:0] exp_r, input logic exp_c);
        int  nbusy;
        bit  seen;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        sub   = s;
`else
        if (s) $display("note: sub requested without subtract build");
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        cin   = 1'b0;
        nbusy = (busy === 1'b1) ? 1 : 0;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
        end
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd8);
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "_result"}, 64'(result), 64'(exp_r));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_c));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [7:0] r_at_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = 8'h00;
        op_b   = 8'h00;
        cin    = 1'b0;
        start1 = 1'b0;
        op_a1  = 1'b0;
        op_b1  = 1'b0;
        cin1   = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        sub    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run8("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);

        // Start during RUN must be ignored
        @(negedge clk);
        op_a = 8'h11; op_b = 8'h22; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        r_at_done = 8'h00;
        repeat (2) @(negedge clk);
        op_a = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                r_at_done = result;
            end
        end
        chk("ign_done_count", 64'(ndone), 64'd1);
        chk("ign_result", 64'(r_at_done), 64'h33);
        chk("ign_hold_result", 64'(result), 64'h33);
        chk("ign_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("mid_no_done", 64'(ndone), 64'd0);
        run8("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);

        // WIDTH=1 instance: 1 + 1 + 1 = 3
        @(negedge clk);
        op_a1 = 1'b1; op_b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("w1_busy", 64'(busy1), 64'd1);
        @(negedge clk);
        chk("w1_done", 64'(done1), 64'd1);
        chk("w1_result", 64'(result1), 64'd1);
        chk("w1_cout", 64'(cout1), 64'd1);
        @(negedge clk);
        chk("w1_done_clear", 64'(done1), 64'd0);

`ifdef SERIAL_ADD_CTRL_SUB_EN
        run8("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run8("sub_00_01", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0);
        run8("sub0_add", 8'h10, 8'h01, 1'b1, 1'b0, 8'h12, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
